// File: rtl/generic_register_file_pkg.sv
// generic_register_file_pkg: FunSel operation codes and shared sizing helper.
package generic_register_file_pkg;
  localparam logic [2:0] FS_DEC     = 3'b000;
  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [2:0] FS_LOAD    = 3'b010;
  localparam logic [2:0] FS_CLR     = 3'b011;
  localparam logic [2:0] FS_LDLO_Z  = 3'b100;
  localparam logic [2:0] FS_LDLO_K  = 3'b101;
  localparam logic [2:0] FS_LDHI_K  = 3'b110;
  localparam logic [2:0] FS_LDLO_SX = 3'b111;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/generic_register_file_if.sv
// generic_register_file_if: write/read/save-restore bus of the register file.
interface generic_register_file_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
);
  localparam int SELW = generic_register_file_pkg::sel_w(NREG);
  logic [WIDTH-1:0] I;
  logic [2:0]       FunSel;
  logic [NREG-1:0]  RegSel;
  logic [SELW-1:0]  OutASel;
  logic [SELW-1:0]  OutBSel;
  logic             Save;
  logic             Restore;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;
  logic             ShadowValid;
  logic             RestoreErr;
  modport master (output I, FunSel, RegSel, OutASel, OutBSel, Save, Restore,
                  input  OutA, OutB, ShadowValid, RestoreErr);
  modport slave  (input  I, FunSel, RegSel, OutASel, OutBSel, Save, Restore,
                  output OutA, OutB, ShadowValid, RestoreErr);
endinterface

// File: rtl/generic_register_file_rf_cell.sv
// rf_cell: one main register with its shadow copy, FunSel update and save/restore muxing.
module rf_cell import generic_register_file_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  input  logic [2:0]       fun_sel,
  input  logic             we,
  input  logic             save,
  input  logic             restore,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH-1:0] main_q, main_d, shadow_q, shadow_d, op_val;
  always_comb begin
    op_val = main_q;
    case (fun_sel)
      FS_DEC:     op_val = main_q - WIDTH'(1);
      FS_INC:     op_val = main_q + WIDTH'(1);
      FS_LOAD:    op_val = i;
      FS_CLR:     op_val = '0;
      FS_LDLO_Z:  op_val = WIDTH'(i[7:0]);
      FS_LDLO_K:  op_val = {main_q[WIDTH-1:8], i[7:0]};
      FS_LDHI_K:  op_val = (main_q & ~WIDTH'(16'hFF00)) | (WIDTH'(i[7:0]) << 8);
      FS_LDLO_SX: op_val = {{(WIDTH-8){i[7]}}, i[7:0]};
      default:    op_val = main_q;
    endcase
    main_d   = restore ? shadow_q : we ? op_val : main_q;
    shadow_d = save ? main_q : shadow_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q   <= '0;
      shadow_q <= '0;
    end else begin
      main_q   <= main_d;
      shadow_q <= shadow_d;
    end
  end
  assign q   = main_q;
  assign nxt = main_d;
endmodule

// File: rtl/generic_register_file.sv
// generic_register_file: NREG x WIDTH register file with shadow bank and optional write-through reads.
module generic_register_file import generic_register_file_pkg::*; #(
  parameter int WIDTH  = 16,
  parameter int NREG   = 8,
  parameter int BYPASS = 0
) (
  input logic                  Clock,
  input logic                  Reset,
  generic_register_file_if.slave bus
);
  localparam int SELW = sel_w(NREG);
  logic [WIDTH-1:0] rd [NREG];
  logic [SELW-1:0]  sel_a, sel_b;
  logic             restore_ok, valid_q, valid_d, err_q, err_d;
  assign restore_ok = bus.Restore & valid_q;
  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_cell
      logic [WIDTH-1:0] q, nxt;
      rf_cell #(.WIDTH(WIDTH)) u_cell (
        .clk(Clock), .rst_n(Reset), .i(bus.I), .fun_sel(bus.FunSel),
        .we(~bus.RegSel[NREG-1-g]), .save(bus.Save), .restore(restore_ok),
        .q(q), .nxt(nxt)
      );
      assign rd[g] = (BYPASS != 0) ? nxt : q;
    end
  endgenerate
  always_comb begin
    valid_d = bus.Save ? 1'b1 : restore_ok ? 1'b0 : valid_q;
    err_d   = bus.Restore & ~valid_q;
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign sel_a           = bus.OutASel;
  assign sel_b           = bus.OutBSel;
  assign bus.OutA        = (int'(sel_a) < NREG) ? rd[sel_a] : '0;
  assign bus.OutB        = (int'(sel_b) < NREG) ? rd[sel_b] : '0;
  assign bus.ShadowValid = valid_q;
  assign bus.RestoreErr  = err_q;
endmodule

// File: tb/tb_generic_register_file.sv
// tb_generic_register_file: directed checks of default, write-through and 6-register instances.
module tb_generic_register_file;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 Clock = ~Clock;
  generic_register_file_if #(.WIDTH(16), .NREG(8)) a ();
  generic_register_file_if #(.WIDTH(16), .NREG(8)) b ();
  generic_register_file_if #(.WIDTH(16), .NREG(6)) c ();
  generic_register_file #(.WIDTH(16), .NREG(8), .BYPASS(0)) dut_a (.Clock(Clock), .Reset(Reset), .bus(a));
  generic_register_file #(.WIDTH(16), .NREG(8), .BYPASS(1)) dut_b (.Clock(Clock), .Reset(Reset), .bus(b));
  generic_register_file #(.WIDTH(16), .NREG(6), .BYPASS(0)) dut_c (.Clock(Clock), .Reset(Reset), .bus(c));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clock);
    #1;
  endtask
  task automatic set(input int idx, input logic [2:0] fs, input logic [15:0] d, input logic sv, input logic rr);
    logic [7:0] rs;
    rs = (idx < 0) ? 8'hFF : ~(8'h80 >> idx);
    a.RegSel = rs; a.FunSel = fs; a.I = d; a.Save = sv; a.Restore = rr;
    b.RegSel = rs; b.FunSel = fs; b.I = d; b.Save = sv; b.Restore = rr;
  endtask
  task automatic op(input int idx, input logic [2:0] fs, input logic [15:0] d, input logic sv, input logic rr);
    set(idx, fs, d, sv, rr);
    tick;
    set(-1, 3'b000, 16'h0, 1'b0, 1'b0);
  endtask
  task automatic sel(input logic [2:0] sa, input logic [2:0] sb);
    a.OutASel = sa; a.OutBSel = sb; b.OutASel = sa; b.OutBSel = sb;
  endtask
  initial begin
    set(-1, 3'b000, 16'h0, 1'b0, 1'b0);
    sel(3'd0, 3'd7);
    c.RegSel = 6'h3F; c.FunSel = 3'b000; c.I = 16'h0; c.Save = 1'b0; c.Restore = 1'b0;
    c.OutASel = 3'd0; c.OutBSel = 3'd7;
    tick;
    Reset = 1'b1;
    check("rst_outa", a.OutA, 16'h0);
    check("rst_outb", a.OutB, 16'h0);
    check("rst_sv", a.ShadowValid, 1'b0);
    check("rst_err", a.RestoreErr, 1'b0);
    check("rst_c_oob", c.OutB, 16'h0);
    sel(3'd2, 3'd2);
    op(2, 3'b010, 16'h1234, 1'b0, 1'b0);
    check("load_r2", a.OutA, 16'h1234);
    check("load_r2_byp", b.OutA, 16'h1234);
    op(2, 3'b000, 16'h0, 1'b0, 1'b0);
    check("dec1_r2", a.OutA, 16'h1233);
    op(2, 3'b000, 16'h0, 1'b0, 1'b0);
    check("dec2_r2", a.OutA, 16'h1232);
    check("same_reg_outb", a.OutB, 16'h1232);
    sel(3'd5, 3'd5);
    op(5, 3'b000, 16'h0, 1'b0, 1'b0);
    check("dec_wrap", a.OutA, 16'hFFFF);
    op(5, 3'b001, 16'h0, 1'b0, 1'b0);
    check("inc_wrap", a.OutB, 16'h0000);
    sel(3'd1, 3'd2);
    op(1, 3'b010, 16'hAB00, 1'b0, 1'b0);
    check("load_r1", a.OutA, 16'hAB00);
    op(1, 3'b101, 16'h00CD, 1'b0, 1'b0);
    check("ldlo_keep", a.OutA, 16'hABCD);
    op(1, 3'b111, 16'h0080, 1'b0, 1'b0);
    check("ldlo_sx", a.OutA, 16'hFF80);
    op(1, 3'b001, 16'h0, 1'b0, 1'b0);
    check("inc_r1", a.OutA, 16'hFF81);
    op(1, 3'b110, 16'h0012, 1'b0, 1'b0);
    check("ldhi_keep", a.OutA, 16'h1281);
    op(1, 3'b100, 16'h3456, 1'b0, 1'b0);
    check("ldlo_zero", a.OutA, 16'h0056);
    op(1, 3'b011, 16'hFFFF, 1'b0, 1'b0);
    check("clr_r1", a.OutA, 16'h0000);
    op(-1, 3'b011, 16'hFFFF, 1'b0, 1'b0);
    check("global_hold", a.OutB, 16'h1232);
    sel(3'd0, 3'd0);
    op(0, 3'b010, 16'h0005, 1'b0, 1'b0);
    check("r0_set", a.OutA, 16'h0005);
    op(0, 3'b010, 16'h0007, 1'b1, 1'b0);
    check("save_wr_same", a.OutA, 16'h0007);
    check("save_sv", a.ShadowValid, 1'b1);
    op(0, 3'b010, 16'h0009, 1'b0, 1'b0);
    check("r0_nine", a.OutA, 16'h0009);
    op(0, 3'b010, 16'h00EE, 1'b0, 1'b1);
    check("restore_val", a.OutA, 16'h0005);
    check("restore_sv", a.ShadowValid, 1'b0);
    check("restore_noerr", a.RestoreErr, 1'b0);
    sel(3'd3, 3'd3);
    op(3, 3'b010, 16'h0042, 1'b0, 1'b1);
    check("rerr_write", a.OutA, 16'h0042);
    check("rerr_pulse", a.RestoreErr, 1'b1);
    tick;
    check("rerr_clear", a.RestoreErr, 1'b0);
    check("rerr_hold", a.OutA, 16'h0042);
    sel(3'd0, 3'd0);
    op(-1, 3'b000, 16'h0, 1'b1, 1'b0);
    op(0, 3'b010, 16'h000A, 1'b0, 1'b0);
    op(-1, 3'b000, 16'h0, 1'b1, 1'b1);
    check("swap_main", a.OutA, 16'h0005);
    check("swap_sv", a.ShadowValid, 1'b1);
    op(-1, 3'b000, 16'h0, 1'b0, 1'b1);
    check("swap_back", a.OutA, 16'h000A);
    op(0, 3'b010, 16'h0033, 1'b1, 1'b1);
    check("sr_nosv_wr", a.OutA, 16'h0033);
    check("sr_nosv_sv", a.ShadowValid, 1'b1);
    check("sr_nosv_err", a.RestoreErr, 1'b1);
    op(-1, 3'b000, 16'h0, 1'b0, 1'b1);
    check("sr_nosv_shadow", a.OutA, 16'h000A);
    sel(3'd4, 3'd4);
    set(4, 3'b010, 16'h7777, 1'b0, 1'b0);
    #1;
    check("byp_same_cycle", b.OutA, 16'h7777);
    check("nobyp_old", a.OutA, 16'h0000);
    tick;
    set(-1, 3'b000, 16'h0, 1'b0, 1'b0);
    check("nobyp_next", a.OutA, 16'h7777);
    op(-1, 3'b000, 16'h0, 1'b1, 1'b0);
    op(4, 3'b010, 16'h1111, 1'b0, 1'b0);
    set(4, 3'b010, 16'h2222, 1'b0, 1'b1);
    #1;
    check("byp_restore", b.OutA, 16'h7777);
    tick;
    set(-1, 3'b000, 16'h0, 1'b0, 1'b0);
    check("restore_r4", a.OutA, 16'h7777);
    c.RegSel = 6'b111110; c.FunSel = 3'b100; c.I = 16'h12AA;
    tick;
    c.RegSel = 6'h3F; c.OutASel = 3'd5; c.OutBSel = 3'd7;
    #1;
    check("c_r5", c.OutA, 16'h00AA);
    check("c_oob7", c.OutB, 16'h0000);
    c.OutBSel = 3'd6;
    #1;
    check("c_oob6", c.OutB, 16'h0000);
    op(-1, 3'b000, 16'h0, 1'b1, 1'b0);
    sel(3'd2, 3'd4);
    set(2, 3'b010, 16'h5555, 1'b1, 1'b1);
    Reset = 1'b0;
    tick;
    Reset = 1'b1;
    set(-1, 3'b000, 16'h0, 1'b0, 1'b0);
    check("rst_pri_sv", a.ShadowValid, 1'b0);
    check("rst_pri_r2", a.OutA, 16'h0000);
    check("rst_pri_r4", a.OutB, 16'h0000);
    check("rst_pri_err", a.RestoreErr, 1'b0);
    op(-1, 3'b000, 16'h0, 1'b0, 1'b1);
    check("rst_shadow_r4", a.OutB, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/generic_register_file.md
GENERIC_REGISTER_FILE -- requirements
Module: generic_register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the register data width; legal values are 16 to 64 and must be a multiple of 8.
REQ-002 SHALL have parameter NREG, default 8, giving the register count; legal values are 2 to 32.
REQ-003 SHALL have parameter BYPASS, default 0; a value of 1 makes the read ports return next-state values (write-through forwarding).
REQ-004 SHALL define SELW = max(1, $clog2(NREG)) as a localparam.
REQ-005 Clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 Reset  in  1  synchronous, active-low reset, sampled on the rising edge of Clock.
REQ-007 I  in  WIDTH  write data.
REQ-008 FunSel  in  3  operation applied to every enabled register.
REQ-009 RegSel  in  NREG  active-low write enables; bit NREG-1 enables R0 and bit 0 enables R(NREG-1).
REQ-010 OutASel, OutBSel  in  SELW  read-port register indices.
REQ-011 Save  in  1  copy the whole main bank into the shadow bank.
REQ-012 Restore  in  1  copy the shadow bank into the main bank.
REQ-013 OutA, OutB  out  WIDTH  read-port data.
REQ-014 ShadowValid  out  1  set when the shadow bank holds a saved context.
REQ-015 RestoreErr  out  1  one-cycle pulse when Restore is requested while ShadowValid=0.

Function
REQ-016 For each enabled register, FunSel SHALL apply as follows (next value):
  - 000: R-1, wrapping modulo 2^WIDTH.
  - 001: R+1, wrapping.
  - 010: I.
  - 011: 0.
  - 100: {0, I[7:0]}.
  - 101: {R[WIDTH-1:8], I[7:0]}.
  - 110: {R[WIDTH-1:16], I[7:0], R[7:0]}, i.e. I[7:0] is loaded into bits 15:8.
  - 111: I[7:0] sign-extended to WIDTH.
REQ-017 A register whose RegSel bit is 1 SHALL hold its value; RegSel all-ones is a global hold.
REQ-018 Writes SHALL take effect at the edge where they are sampled, so the new value is visible on the read ports in the following cycle (BYPASS=0).
REQ-019 With BYPASS=1, OutA/OutB SHALL present the register's next-state value combinationally, with zero-cycle latency.
REQ-020 Read ports SHALL be combinational and independent; both may select the same register.
REQ-021 A read select >= NREG SHALL return 0.
REQ-022 On Save=1, every shadow register SHALL capture the pre-edge main value (writes in the same cycle are not captured), and ShadowValid SHALL be set to 1.
REQ-023 On Restore=1 with ShadowValid=1, every main register SHALL load its shadow value, ShadowValid SHALL be cleared, and any RegSel/FunSel write in that cycle SHALL be discarded.
REQ-024 On Restore=1 with ShadowValid=0, the main bank SHALL take the normal write path and RestoreErr SHALL be 1 for exactly the following cycle.
REQ-025 With Save=1 and Restore=1 together and ShadowValid=1, the banks SHALL swap atomically and ShadowValid SHALL stay 1.
REQ-026 With Save=1 and Restore=1 together and ShadowValid=0, the block SHALL act as Save only and pulse RestoreErr.
REQ-027 With BYPASS=1 during a Restore, the forwarded value on the read ports SHALL be the shadow value.
REQ-028 Save and Restore SHALL each be level-sampled per cycle; holding Save high SHALL re-save every cycle.

Reset
REQ-029 While Reset=0 at a rising edge, all main and shadow registers SHALL become 0, ShadowValid=0 and RestoreErr=0, and Save, Restore, RegSel and FunSel SHALL be ignored.
REQ-030 A reset that arrives during a Save or Restore cycle SHALL take priority; no partial copy is permitted.
REQ-031 Read ports SHALL output 0 in the cycle after reset, for any select value.

Structure
REQ-032 A shared package SHALL hold the FunSel code localparams (FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_LDLO_Z, FS_LDLO_K, FS_LDHI_K, FS_LDLO_SX).
REQ-033 A single sub-module, rf_cell, SHALL implement one main register plus its shadow register, the FunSel next-state logic and the save/restore muxing; the top instantiates NREG copies via generate.
REQ-034 Read muxes SHALL be array-indexed with a range guard, not hand-enumerated cases.

Verification
REQ-035 Reset=0 for 1 cycle, then OutASel=0 and OutBSel=NREG-1 -> OutA=0, OutB=0, ShadowValid=0.
REQ-036 Write R2 via FunSel=010 with I=0x1234, then FunSel=000 twice on R2 -> OutA (sel 2) reads 0x1234, then 0x1233, then 0x1232; decrementing from 0 yields 0xFFFF.
REQ-037 Load R1=0xAB00, then FunSel=101 with I=0x00CD, then FunSel=111 with I=0x0080 -> R1 reads 0xABCD, then 0xFF80.
REQ-038 Set R0=0x0005 and Save; write R0=0x0009; Restore -> R0 reads 0x0005, ShadowValid goes 1 then 0, and the write issued in the Restore cycle is lost.
REQ-039 Restore with ShadowValid=0 while writing R3=0x0042 -> R3 reads 0x0042 and RestoreErr=1 for exactly one cycle.
REQ-040 Instantiate with BYPASS=1, write R4=0x7777 with OutASel=4 -> OutA=0x7777 in the same cycle; also instantiate with NREG=6 and OutBSel=7 -> OutB=0.
